// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM device-side responder: command encodings,
// mode-word fields, error flag indices and the per-bank state type.
package sdram_pkg;

    localparam logic [3:0] CMD_INHIBIT         = 4'b1111;
    localparam logic [3:0] CMD_NOP             = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE          = 4'b0011;
    localparam logic [3:0] CMD_READ            = 4'b0101;
    localparam logic [3:0] CMD_WRITE           = 4'b0100;
    localparam logic [3:0] CMD_BURST_TERMINATE = 4'b0110;
    localparam logic [3:0] CMD_PRECHARGE       = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REFRESH    = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE       = 4'b0000;

    localparam int unsigned MODE_CL_LO = 4;
    localparam int unsigned MODE_CL_HI = 6;
    localparam int unsigned MODE_BL_HI = 2;
    localparam int unsigned ADDR_A10   = 10;

    localparam int unsigned ERR_NOT_OPEN   = 0;
    localparam int unsigned ERR_ACT_BUSY   = 1;
    localparam int unsigned ERR_TRCD       = 2;
    localparam int unsigned ERR_MODE       = 3;
    localparam int unsigned ERR_REFRESH    = 4;
    localparam int unsigned ERR_NO_MODE    = 5;
    localparam int unsigned ERR_CONTENTION = 6;
    localparam int unsigned ERR_W          = 7;

    typedef enum logic [1:0] {
        BankIdle,
        BankActivating,
        BankOpen
    } bank_state_e;

    // Only CL 2/3 and burst length 1 are modelled.
    function automatic logic mode_word_legal(input logic [12:0] mode);
        return ((mode[MODE_CL_HI:MODE_CL_LO] == 3'd2) || (mode[MODE_CL_HI:MODE_CL_LO] == 3'd3))
            && (mode[MODE_BL_HI:0] == 3'b000);
    endfunction

endpackage

// File: rtl/sdram_bank_fsm.sv
// One SDRAM bank: idle/activating/open state, tRCD countdown and latched row.
module sdram_bank_fsm
    import sdram_pkg::*;
#(
    parameter int unsigned ROW_BITS = 2,
    parameter int unsigned TRCD     = 2
) (
    input  logic                clk,
    input  logic                init,
    input  logic                activate,
    input  logic                close,
    input  logic [ROW_BITS-1:0] row_in,
    output logic                is_idle,
    output logic                is_open,
    output logic                is_activating,
    output logic [ROW_BITS-1:0] row
);

    localparam int unsigned CNT_W = (TRCD > 1) ? $clog2(TRCD + 1) : 1;

    bank_state_e      state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state <= BankIdle;
            cnt   <= '0;
            row   <= '0;
        end else begin
            unique case (state)
                BankIdle: begin
                    if (activate) begin
                        row <= row_in;
                        if (TRCD <= 1) begin
                            state <= BankOpen;
                        end else begin
                            state <= BankActivating;
                            cnt   <= CNT_W'(TRCD - 1);
                        end
                    end
                end
                BankActivating: begin
                    if (close) begin
                        state <= BankIdle;
                    end else if (cnt <= CNT_W'(1)) begin
                        state <= BankOpen;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                BankOpen: begin
                    if (close) begin
                        state <= BankIdle;
                    end
                end
                default: state <= BankIdle;
            endcase
        end
    end

    assign is_idle       = (state == BankIdle);
    assign is_open       = (state == BankOpen);
    assign is_activating = (state == BankActivating);

endmodule

// File: rtl/sdram_responder.sv
// Device-side SDRAM model: decodes controller commands, stores masked writes,
// returns reads after the programmed CAS latency and flags protocol errors.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int unsigned ROW_BITS = 2,
    parameter int unsigned TRCD     = 2
) (
    input  logic        clk,
    input  logic        init,
    input  logic        sd_cs,
    input  logic        sd_ras,
    input  logic        sd_cas,
    input  logic        sd_we,
    input  logic [12:0] sd_addr,
    input  logic [1:0]  sd_ba,
    input  logic [1:0]  sd_dqm,
    input  logic [15:0] sd_data_in,
    output logic [15:0] sd_data_out,
    output logic [1:0]  sd_data_oe,
    output logic [12:0] mode_reg,
    output logic        mode_valid,
    output logic [15:0] refresh_count,
    output logic [6:0]  err
);

    localparam int unsigned IDX_BITS = 2 + ROW_BITS + 9;
    localparam int unsigned DEPTH    = 1 << IDX_BITS;

    logic [3:0]          cmd;
    logic                is_act, is_rd, is_wr, is_pre, is_ref, is_lmr, is_col;
    logic [3:0]          bank_idle, bank_open, bank_actv, bank_activate, bank_close;
    logic [ROW_BITS-1:0] bank_row [4];
    logic                all_idle, col_ok;
    logic [IDX_BITS-1:0] idx;
    logic [ERR_W-1:0]    err_set;
    logic [15:0]         mem [DEPTH];
    logic [1:0]          pipe_v;
    logic [15:0]         pipe_d [2];
    logic [1:0]          dqm_q;
    logic                beat_v;
    logic [15:0]         beat_d;

    assign cmd      = {sd_cs, sd_ras, sd_cas, sd_we};
    assign is_act   = (cmd == CMD_ACTIVE);
    assign is_rd    = (cmd == CMD_READ);
    assign is_wr    = (cmd == CMD_WRITE);
    assign is_pre   = (cmd == CMD_PRECHARGE);
    assign is_ref   = (cmd == CMD_AUTO_REFRESH);
    assign is_lmr   = (cmd == CMD_LOAD_MODE);
    assign is_col   = is_rd | is_wr;
    assign all_idle = &bank_idle;
    assign col_ok   = is_col & bank_open[sd_ba];
    assign idx      = {sd_ba, bank_row[sd_ba], sd_addr[8:0]};

    for (genvar b = 0; b < 4; b++) begin : g_bank
        assign bank_activate[b] = is_act && (sd_ba == 2'(b)) && bank_idle[b];
        assign bank_close[b]    = (is_pre && (sd_addr[ADDR_A10] || (sd_ba == 2'(b))))
                               || (col_ok && sd_addr[ADDR_A10] && (sd_ba == 2'(b)));

        sdram_bank_fsm #(
            .ROW_BITS (ROW_BITS),
            .TRCD     (TRCD)
        ) u_bank (
            .clk           (clk),
            .init          (init),
            .activate      (bank_activate[b]),
            .close         (bank_close[b]),
            .row_in        (sd_addr[ROW_BITS-1:0]),
            .is_idle       (bank_idle[b]),
            .is_open       (bank_open[b]),
            .is_activating (bank_actv[b]),
            .row           (bank_row[b])
        );
    end

    always_comb begin
        err_set                 = '0;
        err_set[ERR_NOT_OPEN]   = is_col && bank_idle[sd_ba];
        err_set[ERR_ACT_BUSY]   = is_act && !bank_idle[sd_ba];
        err_set[ERR_TRCD]       = is_col && bank_actv[sd_ba];
        err_set[ERR_MODE]       = is_lmr && !(all_idle && mode_word_legal(sd_addr));
        err_set[ERR_REFRESH]    = is_ref && !all_idle;
        err_set[ERR_NO_MODE]    = (is_act || is_col) && !mode_valid;
        err_set[ERR_CONTENTION] = is_wr && (|sd_data_oe);
    end

    always_ff @(posedge clk) begin
        if (is_wr && col_ok) begin
            if (!sd_dqm[0]) mem[idx][7:0]  <= sd_data_in[7:0];
            if (!sd_dqm[1]) mem[idx][15:8] <= sd_data_in[15:8];
        end
    end

    // Two pipe stages plus the output register give the CL2/CL3 delay.
    assign beat_v = mode_reg[MODE_CL_LO] ? pipe_v[1] : pipe_v[0];
    assign beat_d = mode_reg[MODE_CL_LO] ? pipe_d[1] : pipe_d[0];

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            dqm_q         <= '0;
            pipe_v        <= '0;
            pipe_d[0]     <= '0;
            pipe_d[1]     <= '0;
            sd_data_out   <= '0;
            sd_data_oe    <= '0;
            mode_reg      <= '0;
            mode_valid    <= 1'b0;
            refresh_count <= '0;
            err           <= '0;
        end else begin
            dqm_q       <= sd_dqm;
            pipe_v      <= {pipe_v[0], is_rd & col_ok};
            pipe_d[0]   <= mem[idx];
            pipe_d[1]   <= pipe_d[0];
            // dqm_q holds the mask sampled one edge before the beat appears.
            sd_data_out <= beat_v ? beat_d : 16'h0000;
            sd_data_oe  <= beat_v ? ~dqm_q : 2'b00;
            err         <= err | err_set;
            if (is_lmr && !err_set[ERR_MODE]) begin
                mode_reg   <= sd_addr;
                mode_valid <= 1'b1;
            end
            if (is_ref && all_idle && (refresh_count != 16'hFFFF)) begin
                refresh_count <= refresh_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder with a timestamp-based reference model
// checked every cycle, plus literal expectations at key points.
`timescale 1ns/1ps
module tb_sdram_responder;
    import sdram_pkg::*;

    localparam int TRCD = 2;

    logic        clk = 1'b0;
    logic        init = 1'b1;
    logic        sd_cs = 1'b1, sd_ras = 1'b1, sd_cas = 1'b1, sd_we = 1'b1;
    logic [12:0] sd_addr = '0;
    logic [1:0]  sd_ba = '0, sd_dqm = '0;
    logic [15:0] sd_data_in = '0;
    logic [15:0] sd_data_out;
    logic [1:0]  sd_data_oe;
    logic [12:0] mode_reg;
    logic        mode_valid;
    logic [15:0] refresh_count;
    logic [6:0]  err;

    always #5 clk = ~clk;

    sdram_responder #(
        .ROW_BITS (2),
        .TRCD     (TRCD)
    ) dut (
        .clk           (clk),
        .init          (init),
        .sd_cs         (sd_cs),
        .sd_ras        (sd_ras),
        .sd_cas        (sd_cas),
        .sd_we         (sd_we),
        .sd_addr       (sd_addr),
        .sd_ba         (sd_ba),
        .sd_dqm        (sd_dqm),
        .sd_data_in    (sd_data_in),
        .sd_data_out   (sd_data_out),
        .sd_data_oe    (sd_data_oe),
        .mode_reg      (mode_reg),
        .mode_valid    (mode_valid),
        .refresh_count (refresh_count),
        .err           (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: banks tracked by activation timestamp, reads as scheduled beats.
    int          edge_n = 0;
    bit          m_open [4];
    int          m_act [4];
    logic [1:0]  m_row [4];
    logic [12:0] m_mode;
    bit          m_valid;
    int          m_refresh;
    logic [6:0]  m_err;
    logic [15:0] m_mem [int];
    logic [15:0] beat_data [int];
    logic [1:0]  dqm_hist [int];

    function automatic logic [1:0] exp_oe(input int e);
        if (!beat_data.exists(e)) return 2'b00;
        return ~dqm_hist[e-1];
    endfunction

    function automatic logic [15:0] exp_out(input int e);
        if (!beat_data.exists(e)) return 16'h0000;
        return beat_data[e];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_open[i] = 1'b0;
            m_act[i]  = 0;
            m_row[i]  = '0;
        end
        m_mode    = '0;
        m_valid   = 1'b0;
        m_refresh = 0;
        m_err     = '0;
        beat_data.delete();
    endtask

    task automatic model_step();
        logic [3:0]  c;
        logic [2:0]  f;
        logic [15:0] w;
        int          b, idx, cl;
        bit          busy;
        c    = {sd_cs, sd_ras, sd_cas, sd_we};
        b    = int'(sd_ba);
        cl   = m_valid ? int'(m_mode[6:4]) : 2;
        busy = m_open[0] || m_open[1] || m_open[2] || m_open[3];
        dqm_hist[edge_n] = sd_dqm;
        case (c)
            CMD_ACTIVE: begin
                if (!m_valid) m_err[5] = 1'b1;
                if (m_open[b]) begin
                    m_err[1] = 1'b1;
                end else begin
                    m_open[b] = 1'b1;
                    m_act[b]  = edge_n;
                    m_row[b]  = sd_addr[1:0];
                end
            end
            CMD_READ, CMD_WRITE: begin
                if (!m_valid) m_err[5] = 1'b1;
                if (c == CMD_WRITE && exp_oe(edge_n - 1) != 2'b00) m_err[6] = 1'b1;
                if (!m_open[b]) begin
                    m_err[0] = 1'b1;
                end else if (edge_n < m_act[b] + TRCD) begin
                    m_err[2] = 1'b1;
                end else begin
                    idx = b * 2048 + int'(m_row[b]) * 512 + int'(sd_addr[8:0]);
                    if (c == CMD_WRITE) begin
                        w = m_mem.exists(idx) ? m_mem[idx] : 16'h0000;
                        if (!sd_dqm[0]) w[7:0] = sd_data_in[7:0];
                        if (!sd_dqm[1]) w[15:8] = sd_data_in[15:8];
                        m_mem[idx] = w;
                    end else begin
                        beat_data[edge_n + cl - 1] = m_mem.exists(idx) ? m_mem[idx] : 16'h0000;
                    end
                    if (sd_addr[10]) m_open[b] = 1'b0;
                end
            end
            CMD_PRECHARGE: begin
                for (int i = 0; i < 4; i++) begin
                    if (sd_addr[10] || i == b) m_open[i] = 1'b0;
                end
            end
            CMD_AUTO_REFRESH: begin
                if (busy) m_err[4] = 1'b1;
                else if (m_refresh < 65535) m_refresh++;
            end
            CMD_LOAD_MODE: begin
                f = sd_addr[6:4];
                if (!busy && (f == 3'd2 || f == 3'd3) && sd_addr[2:0] == 3'b000) begin
                    m_mode  = sd_addr;
                    m_valid = 1'b1;
                end else begin
                    m_err[3] = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        edge_n++;
        if (init) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        check("cyc_oe", 32'(sd_data_oe), 32'(exp_oe(edge_n)));
        check("cyc_data", 32'(sd_data_out), 32'(exp_out(edge_n)));
        check("cyc_mode_reg", 32'(mode_reg), 32'(m_mode));
        check("cyc_mode_valid", 32'(mode_valid), 32'(m_valid));
        check("cyc_refresh", 32'(refresh_count), 32'(m_refresh));
        check("cyc_err", 32'(err), 32'(m_err));
    end

    task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [1:0] dqm, input logic [15:0] d);
        @(negedge clk);
        {sd_cs, sd_ras, sd_cas, sd_we} = c;
        sd_ba      = ba;
        sd_addr    = a;
        sd_dqm     = dqm;
        sd_data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        issue(CMD_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_oe"}, 32'(sd_data_oe), 32'h0);
        check({tag, "_data"}, 32'(sd_data_out), 32'h0);
        check({tag, "_mode_reg"}, 32'(mode_reg), 32'h0);
        check({tag, "_mode_valid"}, 32'(mode_valid), 32'h0);
        check({tag, "_refresh"}, 32'(refresh_count), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        init = 1'b0;
        #1;
        check_reset_outputs("reset");

        issue(CMD_LOAD_MODE, 2'd0, 13'h220, 2'b00, 16'h0);
        check("lmr_mode_reg", 32'(mode_reg), 32'h220);
        check("lmr_valid", 32'(mode_valid), 32'h1);
        check("lmr_err", 32'(err), 32'h0);

        // Write with auto-precharge, reopen, read with auto-precharge (CL2).
        issue(CMD_ACTIVE, 2'd1, 13'h003, 2'b00, 16'h0);
        nop();
        issue(CMD_WRITE, 2'd1, 13'h445, 2'b00, 16'hBEEF);
        issue(CMD_ACTIVE, 2'd1, 13'h003, 2'b00, 16'h0);
        nop();
        issue(CMD_READ, 2'd1, 13'h445, 2'b00, 16'h0);
        check("cl2_oe_early", 32'(sd_data_oe), 32'h0);
        nop();
        check("cl2_data", 32'(sd_data_out), 32'hBEEF);
        check("cl2_oe", 32'(sd_data_oe), 32'h3);
        nop();
        check("cl2_oe_after", 32'(sd_data_oe), 32'h0);

        // Masked upper byte, then a read whose lower byte is masked.
        issue(CMD_ACTIVE, 2'd1, 13'h003, 2'b00, 16'h0);
        nop();
        issue(CMD_WRITE, 2'd1, 13'h045, 2'b10, 16'h1234);
        issue(CMD_READ, 2'd1, 13'h045, 2'b00, 16'h0);
        nop();
        check("mask_data", 32'(sd_data_out), 32'hBE34);
        check("mask_oe", 32'(sd_data_oe), 32'h3);
        issue(CMD_READ, 2'd1, 13'h445, 2'b01, 16'h0);
        nop();
        check("dqm_oe", 32'(sd_data_oe), 32'h2);

        // tRCD violation.
        issue(CMD_ACTIVE, 2'd2, 13'h001, 2'b00, 16'h0);
        issue(CMD_READ, 2'd2, 13'h010, 2'b00, 16'h0);
        check("trcd_err", 32'(err[ERR_TRCD]), 32'h1);
        nop();
        check("trcd_no_beat", 32'(sd_data_oe), 32'h0);
        issue(CMD_ACTIVE, 2'd0, 13'h000, 2'b00, 16'h0);
        nop();
        issue(CMD_WRITE, 2'd0, 13'h407, 2'b00, 16'h5A5A);
        nop();
        check("trcd_sticky", 32'(err), 32'h04);
        issue(CMD_PRECHARGE, 2'd0, 13'h400, 2'b00, 16'h0);

        // CL3 read, then a write into the live beat.
        issue(CMD_LOAD_MODE, 2'd0, 13'h230, 2'b00, 16'h0);
        check("cl3_mode_reg", 32'(mode_reg), 32'h230);
        issue(CMD_ACTIVE, 2'd0, 13'h000, 2'b00, 16'h0);
        nop();
        issue(CMD_READ, 2'd0, 13'h007, 2'b00, 16'h0);
        nop();
        check("cl3_oe_early", 32'(sd_data_oe), 32'h0);
        nop();
        check("cl3_data", 32'(sd_data_out), 32'h5A5A);
        check("cl3_oe", 32'(sd_data_oe), 32'h3);
        issue(CMD_WRITE, 2'd0, 13'h008, 2'b00, 16'h1111);
        check("contention_err", 32'(err[ERR_CONTENTION]), 32'h1);

        // Back-to-back reads to different banks.
        issue(CMD_ACTIVE, 2'd1, 13'h003, 2'b00, 16'h0);
        nop();
        issue(CMD_READ, 2'd0, 13'h007, 2'b00, 16'h0);
        issue(CMD_READ, 2'd1, 13'h445, 2'b00, 16'h0);
        nop();
        check("b2b_first", 32'(sd_data_out), 32'h5A5A);
        nop();
        check("b2b_second", 32'(sd_data_out), 32'hBE34);
        nop();
        issue(CMD_PRECHARGE, 2'd0, 13'h400, 2'b00, 16'h0);

        issue(CMD_LOAD_MODE, 2'd0, 13'h250, 2'b00, 16'h0);
        check("bad_mode_err", 32'(err[ERR_MODE]), 32'h1);
        check("bad_mode_keep", 32'(mode_reg), 32'h230);

        issue(CMD_AUTO_REFRESH, 2'd0, 13'h0, 2'b00, 16'h0);
        issue(CMD_AUTO_REFRESH, 2'd0, 13'h0, 2'b00, 16'h0);
        check("refresh_two", 32'(refresh_count), 32'h2);
        issue(CMD_ACTIVE, 2'd0, 13'h000, 2'b00, 16'h0);
        issue(CMD_AUTO_REFRESH, 2'd0, 13'h0, 2'b00, 16'h0);
        check("refresh_busy_err", 32'(err[ERR_REFRESH]), 32'h1);
        check("refresh_busy_cnt", 32'(refresh_count), 32'h2);

        // Reset in the middle of a read beat.
        nop();
        issue(CMD_READ, 2'd0, 13'h007, 2'b00, 16'h0);
        nop();
        nop();
        check("pre_init_oe", 32'(sd_data_oe), 32'h3);
        init = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("init");
        repeat (2) @(posedge clk);
        @(negedge clk);
        init = 1'b0;

        issue(CMD_LOAD_MODE, 2'd0, 13'h220, 2'b00, 16'h0);
        check("post_init_mode", 32'(mode_reg), 32'h220);
        check("post_init_err", 32'(err), 32'h0);
        nop();
        nop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
